// File: rtl/keypad_pkg.sv
// Shared types, key-code constants and helper functions for the 4x4 keypad decoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      EMIT     = 2'd2,
      HOLD     = 2'd3
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'd12;
   localparam logic [3:0] KEY_HASH = 4'd14;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   // Digit keys fill rows 0-2 as 1..9 in reading order; row 3 only holds '0'.
   function automatic logic [3:0] code_to_digit(input logic [3:0] code);
      logic [3:0] r;
      logic [3:0] c;
      r = 4'(code[3:2]);
      c = 4'(code[1:0]);
      if (code[3:2] == 2'd3) return 4'd0;
      return (r * 4'd3) + c + 4'd1;
   endfunction

   // Active-low one-hot pattern with bit idx low; used for column drive and row match.
   function automatic logic [3:0] low_mask(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // {valid, row index}: valid only when exactly one row is pulled low.
   function automatic logic [2:0] single_low(input logic [3:0] rows);
      case (rows)
         4'b1110: return 3'b100;
         4'b1101: return 3'b101;
         4'b1011: return 3'b110;
         4'b0111: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles at all-released.
module keypad_sync (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 4'b1111;
         q    <= 4'b1111;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_decoder.sv
// 4x4 keypad scanner/debouncer emitting one classified strobe per key press.
// KEYPAD_CLEAR_EN enables the clr_out strobe for '#'; otherwise '#' is swallowed.
module keypad_decoder
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 16,
   parameter int unsigned DEBOUNCE_CNT = 50000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       dig_out,
   output logic       op_out,
   output logic       bksp_out,
   output logic       clr_out,
   output logic [3:0] digit_val,
   output logic [1:0] op_code
);

   localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT) + 1;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [DB_W-1:0]  db_cnt;
   logic [1:0]       col_idx;
   logic [1:0]       col_next;
   logic [3:0]       key_code;
   logic [3:0]       rows_s;
   logic [2:0]       hit;

   keypad_sync u_row_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (row_in),
      .q       (rows_s)
   );

   assign col_next = col_idx + 2'd1;
   assign hit      = single_low(rows_s);

`ifndef KEYPAD_CLEAR_EN
   assign clr_out = 1'b0;
`endif

   // Scan / debounce / emit / release-wait sequencer with registered strobes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SCAN;
         div_cnt   <= '0;
         db_cnt    <= '0;
         col_idx   <= 2'd0;
         col_out   <= 4'b1110;
         key_code  <= 4'd0;
         dig_out   <= 1'b0;
         op_out    <= 1'b0;
         bksp_out  <= 1'b0;
         digit_val <= 4'd0;
         op_code   <= OP_ADD;
`ifdef KEYPAD_CLEAR_EN
         clr_out   <= 1'b0;
`endif
      end else begin
         dig_out  <= 1'b0;
         op_out   <= 1'b0;
         bksp_out <= 1'b0;
`ifdef KEYPAD_CLEAR_EN
         clr_out  <= 1'b0;
`endif
         case (state)
            SCAN: begin
               if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                  div_cnt <= '0;
                  if (hit[2]) begin
                     key_code <= {hit[1:0], col_idx};
                     db_cnt   <= '0;
                     state    <= PRESS_DB;
                  end else begin
                     col_idx <= col_next;
                     col_out <= low_mask(col_next);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            PRESS_DB: begin
               if (rows_s != low_mask(key_code[3:2])) begin
                  db_cnt  <= '0;
                  div_cnt <= '0;
                  state   <= SCAN;
               end else if (db_cnt == DB_W'(DEBOUNCE_CNT)) begin
                  state <= EMIT;
                  // Column 3 holds the operators; its row index is the op code.
                  if (key_code[1:0] == 2'd3) begin
                     op_out  <= 1'b1;
                     op_code <= key_code[3:2];
                  end else if (key_code == KEY_STAR) begin
                     bksp_out <= 1'b1;
                  end else if (key_code == KEY_HASH) begin
`ifdef KEYPAD_CLEAR_EN
                     clr_out <= 1'b1;
`endif
                  end else begin
                     dig_out   <= 1'b1;
                     digit_val <= code_to_digit(key_code);
                  end
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end

            EMIT: begin
               db_cnt <= '0;
               state  <= HOLD;
            end

            HOLD: begin
               if (rows_s != 4'b1111) begin
                  db_cnt <= '0;
               end else if (db_cnt == DB_W'(DEBOUNCE_CNT)) begin
                  db_cnt  <= '0;
                  div_cnt <= '0;
                  col_idx <= col_next;
                  col_out <= low_mask(col_next);
                  state   <= SCAN;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end

            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: physical keypad model plus key-map scoreboard.
module tb_keypad_decoder;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DB       = 8;

   logic        clock;
   logic        reset_n;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        dig_out;
   logic        op_out;
   logic        bksp_out;
   logic        clr_out;
   logic [3:0]  digit_val;
   logic [1:0]  op_code;

   logic [15:0] pressed;

   keypad_decoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .dig_out   (dig_out),
      .op_out    (op_out),
      .bksp_out  (bksp_out),
      .clr_out   (clr_out),
      .digit_val (digit_val),
      .op_code   (op_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Switch matrix: a pressed key shorts its row to its column when that column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   // Strobe monitor.
   int unsigned cyc    = 0;
   int unsigned n_dig  = 0;
   int unsigned n_op   = 0;
   int unsigned n_bksp = 0;
   int unsigned n_clr  = 0;
   int unsigned n_excl = 0;

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (reset_n) begin
         if (dig_out)  n_dig  <= n_dig + 1;
         if (op_out)   n_op   <= n_op + 1;
         if (bksp_out) n_bksp <= n_bksp + 1;
         if (clr_out)  n_clr  <= n_clr + 1;
         if ($countones({dig_out, op_out, bksp_out, clr_out}) > 1) n_excl <= n_excl + 1;
      end
   end

   int unsigned passes = 0;
   int unsigned fails  = 0;
   int unsigned total  = 0;
   int unsigned s_dig, s_op, s_bksp, s_clr;
   logic [3:0]  exp_digit;
   logic [1:0]  exp_op;
   string       keymap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
      #2;
   endtask

   task automatic snap();
      s_dig = n_dig; s_op = n_op; s_bksp = n_bksp; s_clr = n_clr;
   endtask

   task automatic wait_strobe(input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (dig_out || op_out || bksp_out || clr_out) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   // Key-map reference: class and value straight from the legend characters.
   task automatic model(input int code, output int ed, output int eo, output int eb, output int ec);
      byte ch;
      ch = keymap[code];
      ed = 0; eo = 0; eb = 0; ec = 0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         ed = 1;
         exp_digit = 4'(ch - 8'h30);
      end else if (ch >= 8'h41 && ch <= 8'h44) begin
         eo = 1;
         exp_op = 2'(ch - 8'h41);
      end else if (ch == 8'h2A) begin
         eb = 1;
      end else begin
`ifdef KEYPAD_CLEAR_EN
         ec = 1;
`endif
      end
   endtask

   task automatic check_counts(input string tag, input int ed, input int eo, input int eb, input int ec);
      chk({tag, "_dig"},   n_dig - s_dig,   ed);
      chk({tag, "_op"},    n_op - s_op,     eo);
      chk({tag, "_bksp"},  n_bksp - s_bksp, eb);
      chk({tag, "_clr"},   n_clr - s_clr,   ec);
      chk({tag, "_dval"},  digit_val,       exp_digit);
      chk({tag, "_opc"},   op_code,         exp_op);
      chk({tag, "_excl"},  n_excl,          0);
   endtask

   // Press one key (optionally a second key halfway through), release, and score it.
   task automatic run_press(input string tag, input int code, input int hold, input int extra);
      int ed, eo, eb, ec;
      snap();
      model(code, ed, eo, eb, ec);
      pressed[code] = 1'b1;
      tick(hold / 2);
      if (extra >= 0) pressed[extra] = 1'b1;
      tick(hold - hold / 2);
      pressed = '0;
      tick(40);
      check_counts(tag, ed, eo, eb, ec);
   endtask

   initial begin
      bit          found;
      int unsigned stable_cyc;
      int          code;
      int          hold;

      keymap    = "123A456B789C*0#D";
      pressed   = '0;
      exp_digit = 4'd0;
      exp_op    = 2'd0;
      reset_n   = 1'b0;
      tick(3);
      chk("rst_col",  col_out, 4'b1110);
      chk("rst_strb", {dig_out, op_out, bksp_out, clr_out}, 4'b0000);
      chk("rst_dval", digit_val, 4'd0);
      chk("rst_opc",  op_code, 2'd0);

      // Reset mid-scan acts asynchronously.
      reset_n = 1'b1;
      tick(7);
      reset_n = 1'b0;
      #1;
      chk("midscan_col",  col_out, 4'b1110);
      chk("midscan_strb", {dig_out, op_out, bksp_out, clr_out}, 4'b0000);
      tick(2);
      reset_n = 1'b1;
      tick(5);

      run_press("key6", 6, 40, -1);

      // Bouncing '1' must not register until it has been stable.
      snap();
      for (int i = 0; i < 10; i++) begin
         pressed[0] = ~pressed[0];
         tick(3);
      end
      pressed[0] = 1'b1;
      stable_cyc = cyc;
      wait_strobe(80, found);
      chk("bounce_found", found, 1'b1);
      chk("bounce_late", (cyc - stable_cyc) >= DB, 1'b1);
      tick(20);
      pressed = '0;
      tick(40);
      exp_digit = 4'd1;
      check_counts("bounce", 1, 0, 0, 0);

      run_press("keyC",    11, 40, -1);
      run_press("keystar", 12, 40, -1);

      // '5' and '8' share column 1: two rows low is no key.
      snap();
      pressed[5] = 1'b1;
      pressed[9] = 1'b1;
      tick(60);
      pressed = '0;
      tick(40);
      check_counts("multi", 0, 0, 0, 0);

      run_press("hold5", 5, 200, 10);
      run_press("keyhash", 14, 40, -1);

      for (int i = 0; i < 8; i++) begin
         code = int'($urandom_range(0, 15));
         hold = int'($urandom_range(40, 90));
         run_press($sformatf("rnd%0d", i), code, hold, -1);
      end

      // Reset during the strobe cycle, then re-detect the still-held key.
      pressed[4] = 1'b1;
      wait_strobe(80, found);
      chk("rstpress_found", found, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("rstpress_dig",  dig_out, 1'b0);
      chk("rstpress_dval", digit_val, 4'd0);
      chk("rstpress_col",  col_out, 4'b1110);
      exp_digit = 4'd0;
      exp_op    = 2'd0;
      tick(2);
      reset_n = 1'b1;
      snap();
      wait_strobe(80, found);
      chk("redetect_found", found, 1'b1);
      tick(20);
      pressed = '0;
      tick(40);
      exp_digit = 4'd4;
      check_counts("redetect", 1, 0, 0, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Scans a 4x4 matrix keypad, debounces it and classifies each press.
- Emits exactly one single-cycle strobe per press: digit, operator or backspace. These strobes feed the calculator control FSM's dig_in/op_in/bksp_in.
- Carries a 4-bit digit value and 2-bit operator code alongside the strobes, for the operand registers and ALU.
- Sits between the board keypad pins and the control stage.

Parameters:
- SCAN_DIV, 16, clock cycles each column is driven before rows are sampled; must be >= 3.
- DEBOUNCE_CNT, 50000, consecutive stable cycles required for both press and release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous
- col_out  out  4  keypad column drive, active-low, one-hot-zero
- dig_out  out  1  one-cycle strobe: digit key pressed
- op_out  out  1  one-cycle strobe: operator key pressed
- bksp_out  out  1  one-cycle strobe: backspace key pressed
- clr_out  out  1  one-cycle strobe: clear key pressed (see Optional Feature)
- digit_val  out  4  value of last digit key, 0-9
- op_code  out  2  code of last operator key

Behaviour:
- Key map, row r / column c, code = 4r+c:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 #  D
- Key classes:
  - Digits -> dig_out.
  - A/B/C/D -> op_out with op_code 0/1/2/3 (add/sub/mul/div).
  - * -> bksp_out.
  - # -> clr_out.
- row_in passes through a 2-flop synchronizer before any use.
- Reset values (asynchronous, immediate):
  - col_out=4'b1110, all strobes 0, digit_val=0, op_code=0.
  - State SCAN, column index 0, counters 0.
- States and transitions:
  - SCAN: drive the current column low. After SCAN_DIV cycles, sample the synced rows.
    - All rows high -> advance column index (3 wraps to 0), reset the divider.
    - Exactly one row low -> latch row/col, go to PRESS_DB.
    - More than one row low -> treat as no key, advance column.
  - PRESS_DB: column drive is frozen. Count cycles while the synced rows equal the latched pattern.
    - Any mismatch -> back to SCAN on the same column, count cleared.
    - Count reaches DEBOUNCE_CNT -> go to EMIT.
  - EMIT: lasts one cycle.
    - Asserts exactly one strobe according to the key class.
    - Updates digit_val (digits only) or op_code (operators only) on the same edge.
    - Then goes to HOLD.
  - HOLD: column frozen. Counter counts consecutive cycles with all synced rows high; any low row clears it. At DEBOUNCE_CNT -> SCAN, advance column.
- Output rules:
  - Strobes are mutually exclusive and never asserted outside EMIT.
  - Holding a key produces no repeat.
  - A second key pressed during HOLD is ignored until full release.
- digit_val and op_code hold their values from the EMIT edge until the next qualifying EMIT. bksp and clr leave both unchanged.
- Latency: when the key is already stable at the sample point, the strobe asserts DEBOUNCE_CNT+1 cycles after the sample edge.
- Reset asserted mid-press: strobes drop immediately. After reset release, a still-held key is re-detected and emitted once.
- All counters saturate-free. Width = clog2 of the parameter +1.

Optional Feature:
- Macro: KEYPAD_CLEAR_EN.
- Defined: # emits a clr_out strobe in EMIT.
- Undefined:
  - clr_out is tied 0.
  - # is debounced and passes through HOLD normally, but EMIT asserts no strobe, so the key is swallowed.
  - No register for the clear path is synthesized.

Decomposition:
- Package keypad_pkg:
  - state enum (SCAN, PRESS_DB, EMIT, HOLD).
  - Key-code constants KEY_STAR=12, KEY_HASH=14.
  - Operator codes OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - Code-to-digit lookup function.
- Sub-module keypad_sync: 2-flop synchronizer with reset to 4'b1111. It is instantiated once for row_in.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
- Reset: assert reset_n=0 mid-scan -> col_out=1110, all strobes 0, digit_val=0, op_code=0 on the same cycle.
- Digit press: hold row1 low while col2 is driven (key 6) for 40 cycles, then release -> exactly one dig_out pulse, digit_val=6, no other strobe.
- Bounce: toggle row0 at col0 every 3 cycles for 30 cycles, then hold stable -> a single dig_out with digit_val=1, only after 8 stable cycles.
- Operator then backspace: press C -> op_out, op_code=2. Then press * -> bksp_out, and op_code stays 2, digit_val unchanged.
- Multi-key/hold: press 5 and 8 together -> no strobe. Hold 5 alone for 200 cycles -> one strobe only. Press 9 during the hold -> ignored.
- Clear macro: press # with KEYPAD_CLEAR_EN defined -> one clr_out pulse. Undefined -> no strobes, outputs unchanged.
